shift_register_n: RTL

- Parametrised multi-mode shift register; next generation of the 8-bit parallel-load/rotate/logical-shift register used in the board-level labs.
- Adds configurable width, left and right shifts, arithmetic shift and serial-in/serial-out.
- Adds multi-step shifts: a start/busy/done handshake performs N single-bit steps, one per clock.
- Sits between switch/key decode logic and LED or downstream datapath consumers.

---
 rtl/shift_register_n.sv | 99 +++++++++
 1 files changed

// File: rtl/shift_register_n.sv
// Parametrised multi-mode shift register: parallel load, rotates, logical/arithmetic/serial shifts.
// Single-cycle load; multi-step ops run one bit per clock behind a start/busy/done handshake.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ROR  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_LSL  = 3'b101,
    OP_SSR  = 3'b110,
    OP_SSL  = 3'b111
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  op_t              op_lat;
  logic [CNT_W-1:0] cnt;

  // Result is {bit leaving the register, next register value} for one step.
  function automatic logic [WIDTH:0] step_fn(input op_t o, input logic [WIDTH-1:0] v,
                                             input logic s);
    logic [WIDTH:0] r;
    case (o)
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_LSR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SSR:  r = {v[0], s, v[WIDTH-1:1]};
      OP_SSL:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_lat     <= OP_LOAD;
      cnt        <= '0;
      q_out      <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_t'(op) == OP_LOAD) begin
              q_out <= data_in;
              done  <= 1'b1;
            end else if (amount == '0) begin
              done <= 1'b1;
            end else begin
              op_lat <= op_t'(op);
              cnt    <= amount;
              busy   <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          {serial_out, q_out} <= step_fn(op_lat, q_out, serial_in);
          cnt <= cnt - 1'b1;
          // Last step: hand back to IDLE so the next start lands while done is high.
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
